lsu_mem_ctrl: RTL and testbench

Load/store memory-access controller that sits beside exu. It takes the effective address (exu addr_load), the store data and the size/sign controls, and runs one AXI-lite-style read or write transaction. It returns the lane-aligned raw read word as exu pre_data, and exu performs sign/zero extension. The pipeline side is a valid/ready handshake, and exactly one transaction is outstanding at a time.

---
 rtl/lsu_pkg.sv | 48 ++++
 rtl/lsu_store_align.sv | 33 +++
 rtl/lsu_mem_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_lsu_mem_ctrl.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store memory-access controller.
package lsu_pkg;

  localparam int         LANES     = 4;
  localparam logic [1:0] RESP_OKAY = 2'b00;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_RD_A = 3'd1;
  localparam logic [2:0] ST_RD_D = 3'd2;
  localparam logic [2:0] ST_WR   = 3'd3;
  localparam logic [2:0] ST_WR_B = 3'd4;
  localparam logic [2:0] ST_DONE = 3'd5;

  typedef enum logic [2:0] {
    IDLE = ST_IDLE,
    RD_A = ST_RD_A,
    RD_D = ST_RD_D,
    WR   = ST_WR,
    WR_B = ST_WR_B,
    DONE = ST_DONE
  } lsu_state_e;

  typedef enum logic [1:0] {
    SZ_NONE = 2'd0,
    SZ_BYTE = 2'd1,
    SZ_HALF = 2'd2,
    SZ_WORD = 2'd3
  } lsu_size_e;

  // Size flags are one-hot; byte takes priority if several are set.
  function automatic lsu_size_e size_decode(input logic b, input logic h, input logic w);
    if (b)      return SZ_BYTE;
    else if (h) return SZ_HALF;
    else if (w) return SZ_WORD;
    else        return SZ_NONE;
  endfunction

  // An access with no size flag is treated like a misaligned one: error, no bus traffic.
  function automatic logic misaligned(input lsu_size_e sz, input logic [1:0] off);
    case (sz)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return off[0];
      SZ_WORD: return (off != 2'b00);
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/lsu_store_align.sv
// Store-side lane alignment: replicates narrow store data across lanes and
// builds the matching byte strobes from size and address offset.
module lsu_store_align
  import lsu_pkg::*;
(
  input  logic [1:0]       size,
  input  logic [1:0]       offset,
  input  logic [31:0]      wdata_in,
  output logic [31:0]      wdata,
  output logic [LANES-1:0] wstrb
);

  // Replication means the slave picks the right bytes purely via wstrb.
  always_comb begin
    wdata = wdata_in;
    wstrb = 4'b1111;
    case (size)
      SZ_BYTE: begin
        wdata = {4{wdata_in[7:0]}};
        wstrb = 4'b0001 << offset;
      end
      SZ_HALF: begin
        wdata = {2{wdata_in[15:0]}};
        wstrb = 4'b0011 << offset;
      end
      default: begin
        wdata = wdata_in;
        wstrb = 4'b1111;
      end
    endcase
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store memory-access controller: one AXI-lite style read or write per
// pipeline request, returning the lane-shifted raw read word.
module lsu_mem_ctrl
  import lsu_pkg::*;
#(
  parameter int DATA_LEN = 32,
  parameter int ADDR_LEN = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                is_load,
  input  logic                is_store,
  input  logic                is_byte,
  input  logic                is_half,
  input  logic                is_word,
  input  logic [ADDR_LEN-1:0] addr,
  input  logic [DATA_LEN-1:0] wdata_in,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_LEN-1:0] pre_data,
  output logic                lsu_err,
  output logic [ADDR_LEN-1:0] araddr,
  output logic                arvalid,
  input  logic                arready,
  input  logic [DATA_LEN-1:0] rdata,
  input  logic [1:0]          rresp,
  input  logic                rvalid,
  output logic                rready,
  output logic [ADDR_LEN-1:0] awaddr,
  output logic                awvalid,
  input  logic                awready,
  output logic [DATA_LEN-1:0] wdata,
  output logic [LANES-1:0]    wstrb,
  output logic                wvalid,
  input  logic                wready,
  input  logic [1:0]          bresp,
  input  logic                bvalid,
  output logic                bready
);

  lsu_state_e          state, state_n;
  lsu_size_e           req_size;
  logic [1:0]          offset, offset_n;
  logic [ADDR_LEN-1:0] araddr_n, awaddr_n, addr_word;
  logic [DATA_LEN-1:0] pre_data_n, wdata_n, algn_wdata;
  logic [LANES-1:0]    wstrb_n, algn_wstrb;
  logic                arvalid_n, rready_n, awvalid_n, wvalid_n, bready_n;
  logic                out_valid_n, lsu_err_n, misal, aw_done, w_done;

  assign in_ready  = (state == IDLE);
  assign req_size  = size_decode(is_byte, is_half, is_word);
  assign misal     = misaligned(req_size, addr[1:0]);
  assign addr_word = {addr[ADDR_LEN-1:2], 2'b00};

  lsu_store_align u_store_align (
    .size     (req_size),
    .offset   (addr[1:0]),
    .wdata_in (wdata_in),
    .wdata    (algn_wdata),
    .wstrb    (algn_wstrb)
  );

  // Next-state and next-output decode; every output below is registered.
  always_comb begin
    state_n     = state;
    offset_n    = offset;
    araddr_n    = araddr;
    arvalid_n   = arvalid;
    rready_n    = rready;
    awaddr_n    = awaddr;
    awvalid_n   = awvalid;
    wdata_n     = wdata;
    wstrb_n     = wstrb;
    wvalid_n    = wvalid;
    bready_n    = bready;
    out_valid_n = out_valid;
    pre_data_n  = pre_data;
    lsu_err_n   = lsu_err;
    aw_done     = !awvalid || awready;
    w_done      = !wvalid || wready;
    case (state)
      IDLE: begin
        if (in_valid) begin
          offset_n = addr[1:0];
          if (!is_load && !is_store) begin
            state_n     = DONE;
            pre_data_n  = '0;
            lsu_err_n   = 1'b0;
            out_valid_n = 1'b1;
          end else if (misal) begin
            state_n     = DONE;
            pre_data_n  = '0;
            lsu_err_n   = 1'b1;
            out_valid_n = 1'b1;
          end else if (is_load) begin
            state_n   = RD_A;
            arvalid_n = 1'b1;
            araddr_n  = addr_word;
          end else begin
            state_n   = WR;
            awvalid_n = 1'b1;
            wvalid_n  = 1'b1;
            awaddr_n  = addr_word;
            wdata_n   = algn_wdata;
            wstrb_n   = algn_wstrb;
          end
        end
      end
      RD_A: begin
        if (arready) begin
          arvalid_n = 1'b0;
          rready_n  = 1'b1;
          state_n   = RD_D;
        end
      end
      RD_D: begin
        if (rvalid) begin
          pre_data_n  = rdata >> {offset, 3'b000};
          lsu_err_n   = (rresp != RESP_OKAY);
          rready_n    = 1'b0;
          out_valid_n = 1'b1;
          state_n     = DONE;
        end
      end
      WR: begin
        // AW and W complete independently; move on once neither is pending.
        if (awvalid && awready) awvalid_n = 1'b0;
        if (wvalid && wready)   wvalid_n  = 1'b0;
        if (aw_done && w_done) begin
          bready_n = 1'b1;
          state_n  = WR_B;
        end
      end
      WR_B: begin
        if (bvalid) begin
          lsu_err_n   = (bresp != RESP_OKAY);
          pre_data_n  = '0;
          bready_n    = 1'b0;
          out_valid_n = 1'b1;
          state_n     = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_n = 1'b0;
          state_n     = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State and output registers; reset abandons any bus transaction in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      offset    <= 2'b00;
      araddr    <= '0;
      arvalid   <= 1'b0;
      rready    <= 1'b0;
      awaddr    <= '0;
      awvalid   <= 1'b0;
      wdata     <= '0;
      wstrb     <= '0;
      wvalid    <= 1'b0;
      bready    <= 1'b0;
      out_valid <= 1'b0;
      pre_data  <= '0;
      lsu_err   <= 1'b0;
    end else begin
      state     <= state_n;
      offset    <= offset_n;
      araddr    <= araddr_n;
      arvalid   <= arvalid_n;
      rready    <= rready_n;
      awaddr    <= awaddr_n;
      awvalid   <= awvalid_n;
      wdata     <= wdata_n;
      wstrb     <= wstrb_n;
      wvalid    <= wvalid_n;
      bready    <= bready_n;
      out_valid <= out_valid_n;
      pre_data  <= pre_data_n;
      lsu_err   <= lsu_err_n;
    end
  end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl with a small AXI-lite memory model and a
// result scoreboard.
module tb_lsu_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, is_load, is_store, is_byte, is_half, is_word;
  logic [31:0] addr, wdata_in;
  logic        out_valid, out_ready, lsu_err;
  logic [31:0] pre_data;
  logic [31:0] araddr, awaddr, wdata, rdata;
  logic        arvalid, arready, rvalid, rready;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic [1:0]  rresp, bresp;
  logic [3:0]  wstrb;

  lsu_mem_ctrl #(.DATA_LEN(32), .ADDR_LEN(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .is_load(is_load), .is_store(is_store),
    .is_byte(is_byte), .is_half(is_half), .is_word(is_word),
    .addr(addr), .wdata_in(wdata_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .pre_data(pre_data), .lsu_err(lsu_err),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  // Memory model: per-channel programmable ready delays, 16-word store.
  logic [31:0] mem [0:15];
  int          ar_delay, aw_delay, w_delay;
  logic [1:0]  rresp_cfg, bresp_cfg;
  int          ar_cnt, aw_cnt, w_cnt, ar_seen;
  logic        rd_pend, aw_done_m, w_done_m, b_pend;
  logic [3:0]  rd_idx, wr_idx, cap_wstrb;
  logic [31:0] cap_wdata;

  assign arready = arvalid && (ar_cnt >= ar_delay);
  assign rvalid  = rd_pend;
  assign rdata   = mem[rd_idx];
  assign rresp   = rresp_cfg;
  assign awready = awvalid && !aw_done_m && (aw_cnt >= aw_delay);
  assign wready  = wvalid && !w_done_m && (w_cnt >= w_delay);
  assign bvalid  = b_pend;
  assign bresp   = bresp_cfg;

  always @(posedge clk) begin
    if (rst) begin
      ar_cnt <= 0; aw_cnt <= 0; w_cnt <= 0; ar_seen <= 0;
      rd_pend <= 1'b0; aw_done_m <= 1'b0; w_done_m <= 1'b0; b_pend <= 1'b0;
      rd_idx <= '0; wr_idx <= '0; cap_wstrb <= '0; cap_wdata <= '0;
      for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
      mem[0] <= 32'hAABB_CCDD;
      mem[1] <= 32'h1122_3344;
    end else begin
      if (arvalid) ar_seen <= ar_seen + 1;
      if (arvalid && arready) begin
        ar_cnt <= 0; rd_pend <= 1'b1; rd_idx <= araddr[5:2];
      end else if (arvalid) ar_cnt <= ar_cnt + 1;
      if (rvalid && rready) rd_pend <= 1'b0;
      if (awvalid && awready) begin
        aw_done_m <= 1'b1; wr_idx <= awaddr[5:2]; aw_cnt <= 0;
      end else if (awvalid && !aw_done_m) aw_cnt <= aw_cnt + 1;
      if (wvalid && wready) begin
        w_done_m <= 1'b1; cap_wdata <= wdata; cap_wstrb <= wstrb; w_cnt <= 0;
      end else if (wvalid && !w_done_m) w_cnt <= w_cnt + 1;
      if (aw_done_m && w_done_m && !b_pend) begin
        b_pend <= 1'b1; aw_done_m <= 1'b0; w_done_m <= 1'b0;
        for (int i = 0; i < 4; i++)
          if (cap_wstrb[i]) mem[wr_idx][8*i +: 8] <= cap_wdata[8*i +: 8];
      end
      if (bvalid && bready) b_pend <= 1'b0;
    end
  end

  typedef struct packed {
    logic [31:0] data;
    logic        err;
    logic        chk_data;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Present one request for a single cycle; returns just after the accept edge.
  task automatic do_req(input logic ld, input logic st, input logic [2:0] bhw,
                        input logic [31:0] a, input logic [31:0] wd);
    in_valid = 1'b1; is_load = ld; is_store = st;
    is_byte = bhw[2]; is_half = bhw[1]; is_word = bhw[0];
    addr = a; wdata_in = wd;
    chk1("in_ready_at_accept", in_ready, 1'b1);
    tick();
    in_valid = 1'b0; is_load = 1'b0; is_store = 1'b0;
    is_byte = 1'b0; is_half = 1'b0; is_word = 1'b0;
    addr = 32'h0; wdata_in = 32'h0;
  endtask

  // Wait (bounded) for out_valid, then pop the scoreboard and compare.
  task automatic await_out(input string tag, input int max, output int cyc);
    exp_t e;
    cyc = 0;
    while (!out_valid && cyc < max) begin
      tick();
      cyc++;
    end
    chk1({tag, "_out_valid"}, out_valid, 1'b1);
    if (sb.size() == 0) begin
      chk32({tag, "_sb_nonempty"}, 32'(sb.size()), 32'd1);
    end else begin
      e = sb.pop_front();
      if (e.chk_data) chk32({tag, "_pre_data"}, pre_data, e.data);
      chk1({tag, "_lsu_err"}, lsu_err, e.err);
    end
  endtask

  task automatic release_out(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk1({tag, "_out_valid_clr"}, out_valid, 1'b0);
    chk1({tag, "_in_ready_back"}, in_ready, 1'b1);
  endtask

  int cyc;
  int ar_before;

  initial begin
    rst = 1'b1; in_valid = 1'b0; is_load = 1'b0; is_store = 1'b0;
    is_byte = 1'b0; is_half = 1'b0; is_word = 1'b0;
    addr = 32'h0; wdata_in = 32'h0; out_ready = 1'b0;
    ar_delay = 0; aw_delay = 0; w_delay = 0; rresp_cfg = 2'b00; bresp_cfg = 2'b00;
    tick(); tick();

    chk1 ("rst_in_ready",  in_ready,  1'b1);
    chk1 ("rst_out_valid", out_valid, 1'b0);
    chk1 ("rst_arvalid",   arvalid,   1'b0);
    chk1 ("rst_awvalid",   awvalid,   1'b0);
    chk1 ("rst_wvalid",    wvalid,    1'b0);
    chk1 ("rst_rready",    rready,    1'b0);
    chk1 ("rst_bready",    bready,    1'b0);
    chk1 ("rst_lsu_err",   lsu_err,   1'b0);
    chk32("rst_pre_data",  pre_data,  32'h0);
    chk32("rst_wstrb",     {28'h0, wstrb}, 32'h0);
    rst = 1'b0;
    tick();

    // Load word, zero-wait memory.
    sb.push_back('{data: 32'h1122_3344, err: 1'b0, chk_data: 1'b1});
    do_req(1'b1, 1'b0, 3'b001, 32'h8000_0004, 32'h0);
    chk1 ("ldw_arvalid", arvalid, 1'b1);
    chk32("ldw_araddr",  araddr,  32'h8000_0004);
    await_out("ldw", 10, cyc);
    chk32("ldw_latency", 1 + cyc, 32'd3);
    release_out("ldw");

    // Load byte at offset 3 with AR ready delayed two cycles.
    ar_delay = 2;
    sb.push_back('{data: 32'h0000_00AA, err: 1'b0, chk_data: 1'b1});
    do_req(1'b1, 1'b0, 3'b100, 32'h8000_0003, 32'h0);
    for (int i = 0; i < 3; i++) begin
      chk1 ("ldb_arvalid_hold", arvalid, 1'b1);
      chk32("ldb_araddr_hold",  araddr,  32'h8000_0000);
      if (i < 2) chk1("ldb_arready_wait", arready, 1'b0);
      if (i < 2) tick();
    end
    await_out("ldb", 10, cyc);
    release_out("ldb");
    ar_delay = 0;

    // Store half at offset 2: AW ready at once, W ready two cycles later.
    aw_delay = 0; w_delay = 2;
    sb.push_back('{data: 32'h0, err: 1'b0, chk_data: 1'b1});
    do_req(1'b0, 1'b1, 3'b010, 32'h8000_0002, 32'h0000_BEEF);
    chk1 ("sth_awvalid", awvalid, 1'b1);
    chk1 ("sth_wvalid",  wvalid,  1'b1);
    chk32("sth_awaddr",  awaddr,  32'h8000_0000);
    chk32("sth_wdata",   wdata,   32'hBEEF_BEEF);
    chk32("sth_wstrb",   {28'h0, wstrb}, 32'hC);
    tick();
    chk1 ("sth_c2_awvalid_drop", awvalid, 1'b0);
    chk1 ("sth_c2_wvalid_hold",  wvalid,  1'b1);
    chk1 ("sth_c2_bready",       bready,  1'b0);
    chk32("sth_c2_wdata_stable", wdata,   32'hBEEF_BEEF);
    tick();
    chk1 ("sth_c3_wvalid_hold",  wvalid,  1'b1);
    chk1 ("sth_c3_bready",       bready,  1'b0);
    tick();
    chk1 ("sth_c4_wvalid_drop",  wvalid,  1'b0);
    chk1 ("sth_c4_bready",       bready,  1'b1);
    await_out("sth", 10, cyc);
    release_out("sth");
    chk32("sth_mem_word", mem[0], 32'hBEEF_CCDD);
    w_delay = 0;

    // Misaligned word load: error result, no read address ever issued.
    ar_before = ar_seen;
    sb.push_back('{data: 32'h0, err: 1'b1, chk_data: 1'b0});
    do_req(1'b1, 1'b0, 3'b001, 32'h8000_0001, 32'h0);
    await_out("misal", 10, cyc);
    chk32("misal_latency", 1 + cyc, 32'd1);
    chk32("misal_no_ar", ar_seen, ar_before);
    release_out("misal");

    // Neither load nor store: empty result.
    sb.push_back('{data: 32'h0, err: 1'b0, chk_data: 1'b1});
    do_req(1'b0, 1'b0, 3'b001, 32'h8000_0008, 32'h0);
    await_out("nop", 10, cyc);
    release_out("nop");

    // Store byte with SLVERR, consumer stalls four cycles; a new request
    // offered meanwhile must be ignored.
    bresp_cfg = 2'b10;
    sb.push_back('{data: 32'h0, err: 1'b1, chk_data: 1'b1});
    do_req(1'b0, 1'b1, 3'b100, 32'h8000_0001, 32'h0000_005A);
    chk32("stb_wstrb", {28'h0, wstrb}, 32'h2);
    chk32("stb_wdata", wdata, 32'h5A5A_5A5A);
    await_out("stb", 10, cyc);
    in_valid = 1'b1; is_load = 1'b1; is_word = 1'b1; addr = 32'h8000_0004;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk1 ("stb_hold_out_valid", out_valid, 1'b1);
      chk1 ("stb_hold_in_ready",  in_ready,  1'b0);
      chk1 ("stb_hold_lsu_err",   lsu_err,   1'b1);
      chk1 ("stb_hold_no_ar",     arvalid,   1'b0);
    end
    in_valid = 1'b0; is_load = 1'b0; is_word = 1'b0; addr = 32'h0;
    release_out("stb");
    chk32("stb_mem_word", mem[0], 32'hBEEF_5ADD);
    bresp_cfg = 2'b00;

    // Reset while waiting for read data.
    do_req(1'b1, 1'b0, 3'b001, 32'h8000_0004, 32'h0);
    tick();
    chk1("rstmid_rready_before", rready, 1'b1);
    rst = 1'b1;
    tick();
    chk1("rstmid_rready",    rready,    1'b0);
    chk1("rstmid_in_ready",  in_ready,  1'b1);
    chk1("rstmid_out_valid", out_valid, 1'b0);
    chk1("rstmid_arvalid",   arvalid,   1'b0);
    rst = 1'b0;
    tick();

    // Controller is fully usable after the mid-transaction reset.
    sb.push_back('{data: 32'h1122_3344, err: 1'b0, chk_data: 1'b1});
    do_req(1'b1, 1'b0, 3'b001, 32'h8000_0004, 32'h0);
    await_out("post_rst", 10, cyc);
    release_out("post_rst");

    chk32("sb_drained", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
